// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and multi-cycle
// multiply occupancy of EX, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rsID,
  input  logic [4:0]       rtID,
  input  logic             useRtID,
  input  logic             memReadEX,
  input  logic [4:0]       rtEX,
  input  logic             mulStartEX,
  input  logic             branchTakenID,
  input  logic             jumpID,
  input  logic             clrCnt,
  output logic             pcWrite,
  output logic             stallIFID,
  output logic             flushIFID,
  output logic             bubbleIDEX,
  output logic             holdIDEX,
  output logic             bubbleEXMEM,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned MCNT_W = 4;
  localparam logic [MCNT_W-1:0] MUL_INIT = MCNT_W'(MUL_LATENCY - 2);
  localparam logic LAT_GT1 = (MUL_LATENCY > 1);
  localparam logic LAT_GT2 = (MUL_LATENCY > 2);
  localparam logic LAT_EQ2 = (MUL_LATENCY == 2);

  typedef enum logic [1:0] {RUN, MUL, DRAIN} state_t;

  state_t            state;
  logic [MCNT_W-1:0] mcnt;
  logic              mul_stall;
  logic              load_use;
  logic              redirect;

  assign mul_stall = (state == RUN && mulStartEX && LAT_GT1) || (state == MUL);
  assign load_use  = memReadEX && (rtEX != 5'd0) &&
                     ((rtEX == rsID) || (useRtID && (rtEX == rtID)));
  assign redirect  = branchTakenID || jumpID;

  // Multiply occupancy sequencer; DRAIN ignores mulStartEX since the same op is still in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mulStartEX && LAT_GT2) begin
            state <= MUL;
            mcnt  <= MUL_INIT;
          end else if (mulStartEX && LAT_EQ2) begin
            state <= DRAIN;
          end
        end
        MUL: begin
          if (mcnt == MCNT_W'(1)) state <= DRAIN;
          else                    mcnt  <= mcnt - MCNT_W'(1);
        end
        DRAIN:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Priority: multiply stall > load-use > redirect; forced pass-through while in reset.
  always_comb begin
    pcWrite     = 1'b1;
    stallIFID   = 1'b0;
    flushIFID   = 1'b0;
    bubbleIDEX  = 1'b0;
    holdIDEX    = 1'b0;
    bubbleEXMEM = 1'b0;
    if (rst_n) begin
      if (mul_stall) begin
        pcWrite     = 1'b0;
        stallIFID   = 1'b1;
        holdIDEX    = 1'b1;
        bubbleEXMEM = 1'b1;
      end else if (load_use) begin
        pcWrite    = 1'b0;
        stallIFID  = 1'b1;
        bubbleIDEX = 1'b1;
      end else if (redirect) begin
        flushIFID = 1'b1;
      end
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else if (clrCnt) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (!pcWrite && (stallCycles != {CNT_W{1'b1}})) stallCycles <= stallCycles + CNT_W'(1);
      if (flushIFID && (flushCount != {CNT_W{1'b1}}))  flushCount  <= flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (latency 4, 1, 2) share stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rsID, rtID, rtEX;
  logic       useRtID, memReadEX, mulStartEX, branchTakenID, jumpID, clrCnt;

  logic        a_pc, a_stall, a_flush, a_bub, a_hold, a_bubm;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_stall, b_flush, b_bub, b_hold, b_bubm;
  logic [3:0]  b_sc, b_fc;
  logic        c_pc, c_stall, c_flush, c_bub, c_hold, c_bubm;
  logic [15:0] c_sc, c_fc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rsID(rsID), .rtID(rtID), .useRtID(useRtID),
    .memReadEX(memReadEX), .rtEX(rtEX), .mulStartEX(mulStartEX),
    .branchTakenID(branchTakenID), .jumpID(jumpID), .clrCnt(clrCnt),
    .pcWrite(a_pc), .stallIFID(a_stall), .flushIFID(a_flush), .bubbleIDEX(a_bub),
    .holdIDEX(a_hold), .bubbleEXMEM(a_bubm), .stallCycles(a_sc), .flushCount(a_fc));

  pipeline_hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rsID(rsID), .rtID(rtID), .useRtID(useRtID),
    .memReadEX(memReadEX), .rtEX(rtEX), .mulStartEX(mulStartEX),
    .branchTakenID(branchTakenID), .jumpID(jumpID), .clrCnt(clrCnt),
    .pcWrite(b_pc), .stallIFID(b_stall), .flushIFID(b_flush), .bubbleIDEX(b_bub),
    .holdIDEX(b_hold), .bubbleEXMEM(b_bubm), .stallCycles(b_sc), .flushCount(b_fc));

  pipeline_hazard_ctrl #(.MUL_LATENCY(2), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .rsID(rsID), .rtID(rtID), .useRtID(useRtID),
    .memReadEX(memReadEX), .rtEX(rtEX), .mulStartEX(mulStartEX),
    .branchTakenID(branchTakenID), .jumpID(jumpID), .clrCnt(clrCnt),
    .pcWrite(c_pc), .stallIFID(c_stall), .flushIFID(c_flush), .bubbleIDEX(c_bub),
    .holdIDEX(c_hold), .bubbleEXMEM(c_bubm), .stallCycles(c_sc), .flushCount(c_fc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rsID = 5'd0; rtID = 5'd0; rtEX = 5'd0; useRtID = 1'b0; memReadEX = 1'b0;
    mulStartEX = 1'b0; branchTakenID = 1'b0; jumpID = 1'b0; clrCnt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hazard();
    idle();
    memReadEX = 1'b1; rtEX = 5'd5; rsID = 5'd5;
  endtask

  initial begin
    // Reset with hostile inputs: outputs must be pass-through.
    rst_n = 1'b0;
    idle();
    memReadEX = 1'b1; rtEX = 5'd5; rsID = 5'd5; mulStartEX = 1'b1; branchTakenID = 1'b1;
    #2;
    check("rst_pcWrite", 32'(a_pc), 32'd1);
    check("rst_ctrl", 32'({a_stall, a_flush, a_bub, a_hold, a_bubm}), 32'd0);
    check("rst_stallCycles", 32'(a_sc), 32'd0);
    check("rst_flushCount", 32'(a_fc), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use on rs.
    hazard();
    #1;
    check("lu_pcWrite", 32'(a_pc), 32'd0);
    check("lu_ctrl", 32'({a_stall, a_flush, a_bub, a_hold, a_bubm}), 32'b10100);
    tick();
    idle();
    #1;
    check("lu_after_pass", 32'({a_pc, a_stall, a_bub}), 32'b100);
    check("lu_stallCycles", 32'(a_sc), 32'd1);

    // Zero register and rt-unused cases.
    memReadEX = 1'b1; rtEX = 5'd0; rsID = 5'd0;
    #1;
    check("zero_reg_nostall", 32'(a_pc), 32'd1);
    rtEX = 5'd7; rtID = 5'd7; rsID = 5'd1; useRtID = 1'b0;
    #1;
    check("rt_unused_nostall", 32'(a_pc), 32'd1);
    useRtID = 1'b1;
    #1;
    check("rt_used_stall", 32'({a_pc, a_stall, a_bub}), 32'b011);
    tick();
    check("rt_stallCycles", 32'(a_sc), 32'd2);

    // Branch and load-use collision, then redirect, then jump.
    idle();
    memReadEX = 1'b1; rtEX = 5'd3; rsID = 5'd3; branchTakenID = 1'b1;
    #1;
    check("coll_ctrl", 32'({a_pc, a_stall, a_flush, a_bub}), 32'b0101);
    tick();
    memReadEX = 1'b0;
    #1;
    check("br_flush", 32'({a_pc, a_stall, a_flush, a_bub}), 32'b1010);
    tick();
    check("br_counts", 32'({a_sc, a_fc}), {16'd3, 16'd1});
    idle();
    jumpID = 1'b1;
    #1;
    check("jmp_flush", 32'({a_pc, a_flush}), 32'b11);
    tick();
    check("jmp_flushCount", 32'(a_fc), 32'd2);

    // Multiply held 4 cycles with branch held; latency 4 / 1 / 2 instances.
    idle();
    mulStartEX = 1'b1; branchTakenID = 1'b1;
    #1;
    check("mulT0_a", 32'({a_pc, a_stall, a_flush, a_hold, a_bubm, a_bub}), 32'b010110);
    check("mulT0_b", 32'({b_pc, b_flush, b_hold}), 32'b110);
    check("mulT0_c", 32'({c_pc, c_hold, c_flush}), 32'b010);
    tick();
    check("mulT1_a", 32'({a_pc, a_flush, a_hold, a_bubm}), 32'b0011);
    check("mulT1_c_drain", 32'({c_pc, c_hold, c_flush}), 32'b101);
    tick();
    check("mulT2_a", 32'({a_pc, a_flush, a_hold, a_bubm}), 32'b0011);
    check("mulT2_c_b2b", 32'({c_pc, c_hold, c_flush}), 32'b010);
    tick();
    check("mulT3_a_drain", 32'({a_pc, a_stall, a_flush, a_hold, a_bubm}), 32'b10100);
    check("mulT3_c_drain", 32'({c_pc, c_hold, c_flush}), 32'b101);
    check("mul_b_nostall", 32'(b_pc), 32'd1);
    tick();
    idle();
    #1;
    check("mul_counts", 32'({a_sc, a_fc}), {16'd6, 16'd3});
    check("mul_after_pass", 32'({a_pc, a_hold}), 32'b10);

    // Reset asserted while in MUL.
    mulStartEX = 1'b1;
    tick();
    idle();
    #1;
    check("inmul_stall", 32'({a_pc, a_hold}), 32'b01);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({a_pc, a_stall, a_hold, a_bubm}), 32'b1000);
    check("midrst_counts", 32'({a_sc, a_fc}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_pass", 32'({a_pc, a_hold}), 32'b10);
    check("postrst_counts", 32'(a_sc), 32'd0);

    // Clear concurrent with an increment.
    hazard();
    tick();
    check("pre_clr", 32'(a_sc), 32'd1);
    clrCnt = 1'b1;
    tick();
    check("clr_wins_a", 32'(a_sc), 32'd0);
    check("clr_wins_b", 32'(b_sc), 32'd0);

    // Saturation of the 4-bit counter.
    clrCnt = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_b", 32'(b_sc), 32'd15);
    check("nosat_a", 32'(a_sc), 32'd20);
    tick();
    check("sat_b_hold", 32'(b_sc), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
